// File: rtl/prvp_spi_master_rx_multi_if.sv
// Received-word stream between the SPI RX datapath and its consumer.
// The master drives data/valid/last; the slave returns ready.
interface prvp_spi_master_rx_multi_if #(
   parameter int DATA_W = 32
);
   logic [DATA_W-1:0] data;
   logic              data_valid;
   logic              data_ready;
   logic              last_o;

   modport master (
      output data, data_valid, last_o,
      input  data_ready
   );

   modport slave (
      input  data, data_valid, last_o,
      output data_ready
   );
endinterface

// File: rtl/prvp_spi_master_rx_multi.sv
// SPI master receive datapath: 1/2/4 lanes, MSB/LSB-first, word output.
// Gates the SPI clock while a completed word cannot be handed over.
module prvp_spi_master_rx_multi #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             en,
   input  logic             abort,
   input  logic [1:0]       mode,
   input  logic             lsb_first,
   input  logic [CNT_W-1:0] counter_in,
   input  logic             counter_in_upd,
   input  logic             rx_edge,
   input  logic [3:0]       sdi,
   prvp_spi_master_rx_multi_if.master rx,
   output logic             rx_done,
   output logic             clk_en_o,
   output logic             busy_o
);
   localparam int WC_W = $clog2(DATA_W + 1);

   typedef enum logic [1:0] {IDLE, RECEIVE, STALL, DRAIN} state_t;

   state_t            state;
   logic [CNT_W-1:0]  len_q;
   logic [CNT_W-1:0]  tgt_q;
   logic [CNT_W-1:0]  ecnt;
   logic [CNT_W-1:0]  ecnt_nx;
   logic [CNT_W-1:0]  e_in;
   logic [WC_W-1:0]   wcnt;
   logic [WC_W-1:0]   wn;
   logic [WC_W-1:0]   wtgt;
   logic [WC_W-1:0]   bits;
   logic [1:0]        lsh_in;
   logic [1:0]        lsh_q;
   logic              lsb_q;
   logic [DATA_W-1:0] sh;
   logic [DATA_W-1:0] sh_nx;
   logic [DATA_W-1:0] word;
   logic              last_e;
   logic              bound;
   logic              stall_c;
   logic              hon;
   logic              accept;

   assign busy_o = (state != IDLE);

   // Edge bookkeeping, clock gating, next shift value and justified word.
   always_comb begin
      lsh_in   = (mode == 2'd1) ? 2'd1 :
                 (mode == 2'd2) ? 2'd2 : 2'd0;
      e_in     = len_q >> lsh_in;
      wtgt     = WC_W'(DATA_W >> lsh_q);
      wn       = wcnt + WC_W'(1);
      ecnt_nx  = ecnt + CNT_W'(1);
      last_e   = (ecnt_nx == tgt_q);
      bound    = (wn == wtgt) || last_e;
      accept   = rx.data_valid && rx.data_ready;
      stall_c  = rx.data_valid && !rx.data_ready && bound;
      clk_en_o = (state == RECEIVE) && !stall_c && !abort;
      hon      = rx_edge && clk_en_o;
      rx_done  = hon && last_e;
      sh_nx    = sh;
      case (lsh_q)
         2'd1: sh_nx = lsb_q ? {sdi[1:0], sh[DATA_W-1:2]}
                             : {sh[DATA_W-3:0], sdi[1:0]};
         2'd2: sh_nx = lsb_q ? {sdi[3:0], sh[DATA_W-1:4]}
                             : {sh[DATA_W-5:0], sdi[3:0]};
         default: sh_nx = lsb_q ? {sdi[0], sh[DATA_W-1:1]}
                                : {sh[DATA_W-2:0], sdi[0]};
      endcase
      bits = wn << lsh_q;
      word = lsb_q ? (sh_nx >> (WC_W'(DATA_W) - bits)) : sh_nx;
   end

   // Transfer FSM, counters, shift register and registered output stage.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state         <= IDLE;
         len_q         <= CNT_W'(8);
         tgt_q         <= '0;
         ecnt          <= '0;
         wcnt          <= '0;
         lsh_q         <= 2'd0;
         lsb_q         <= 1'b0;
         sh            <= '0;
         rx.data       <= '0;
         rx.data_valid <= 1'b0;
         rx.last_o     <= 1'b0;
      end else begin
         if (counter_in_upd) len_q <= counter_in;
         if (abort) begin
            state         <= IDLE;
            ecnt          <= '0;
            wcnt          <= '0;
            sh            <= '0;
            rx.data_valid <= 1'b0;
            rx.last_o     <= 1'b0;
         end else begin
            if (accept) rx.data_valid <= 1'b0;
            unique case (state)
               IDLE: begin
                  if (en && e_in != '0) begin
                     state <= RECEIVE;
                     lsh_q <= lsh_in;
                     lsb_q <= lsb_first;
                     tgt_q <= e_in;
                     ecnt  <= '0;
                     wcnt  <= '0;
                     sh    <= '0;
                  end
               end
               RECEIVE: begin
                  if (stall_c) begin
                     state <= STALL;
                  end else if (hon) begin
                     ecnt <= ecnt_nx;
                     if (bound) begin
                        rx.data       <= word;
                        rx.data_valid <= 1'b1;
                        rx.last_o     <= last_e;
                        wcnt          <= '0;
                        sh            <= '0;
                        if (last_e) state <= DRAIN;
                     end else begin
                        wcnt <= wn;
                        sh   <= sh_nx;
                     end
                  end
               end
               STALL: if (accept) state <= RECEIVE;
               DRAIN: if (accept) state <= IDLE;
            endcase
         end
      end
   end
endmodule
